// File: rtl/rf_write_scheduler.sv
// Write-port scheduler and long-op scoreboard for the RegFile: arbitrates writeback against
// buffered long-latency results, tracks pending destinations and stalls decode on hazards.
module rf_write_scheduler #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic [4:0]  id_rd_addr,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        id_writes_rd,
    input  logic        id_is_long,
    output logic        id_stall,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_addr,
    input  logic [31:0] lu_data,
    output logic        rf_regwrite,
    output logic [4:0]  rf_writereg_addr,
    output logic [31:0] rf_writedata,
    output logic        pipe_hold,
    output logic [31:0] busy_vec,
    output logic [3:0]  outstanding
);

    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    logic [31:1]       busy_q;
    logic [3:0]        outstanding_q;
    logic [4:0]        fifo_addr [2];
    logic [31:0]       fifo_data [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              hold_q;

    logic        head_valid;
    logic [4:0]  head_addr;
    logic [31:0] head_data;
    logic        head_nz;
    logic        grant_head;
    logic        grant_wb;
    logic        retire;
    logic        hazard;
    logic        issue_long;
    logic        accept;
    logic        hold_next;
    logic [31:0] busy_next;

    assign busy_vec    = {busy_q, 1'b0};
    assign outstanding = outstanding_q;
    assign pipe_hold   = hold_q;

    assign head_valid = (fifo_cnt != 2'd0);
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];
    assign head_nz    = (head_addr != 5'd0);

    // A held cycle belongs to the starved head; otherwise writeback wins the port.
    always_comb begin
        grant_head = 1'b0;
        grant_wb   = 1'b0;
        if (!rst) begin
            if (hold_q && head_valid)
                grant_head = 1'b1;
            else if (wb_we && (wb_addr != 5'd0) && !hold_q)
                grant_wb = 1'b1;
            else if (head_valid && head_nz)
                grant_head = 1'b1;
        end
    end

    assign rf_regwrite      = grant_wb | (grant_head & head_nz);
    assign rf_writereg_addr = grant_head ? head_addr : (grant_wb ? wb_addr : 5'd0);
    assign rf_writedata     = grant_head ? head_data : (grant_wb ? wb_data : 32'd0);

    assign retire = head_valid & ~rst & (~head_nz | grant_head);

    assign hazard = (id_uses_rs1 && (id_rs1_addr != 5'd0) && busy_vec[id_rs1_addr])
                  | (id_uses_rs2 && (id_rs2_addr != 5'd0) && busy_vec[id_rs2_addr])
                  | (id_writes_rd && (id_rd_addr != 5'd0) && busy_vec[id_rd_addr])
                  | (id_is_long && (outstanding_q == 4'(MAX_OUTSTANDING)));

    assign id_stall   = id_valid & (rst | hazard | hold_q);
    assign issue_long = id_valid & ~id_stall & id_is_long;

    assign lu_ready = (fifo_cnt < 2'd2) & ~rst;
    assign accept   = lu_valid & lu_ready;

    assign hold_next = head_valid & ~retire & head_nz
                     & (wait_cnt == WAIT_W'(STARVE_LIMIT - 1));

    // Issue-set and retire-clear never collide: issuing to a busy rd stalls.
    always_comb begin
        busy_next = busy_vec;
        if (retire && head_nz)
            busy_next[head_addr] = 1'b0;
        if (issue_long && id_writes_rd && (id_rd_addr != 5'd0))
            busy_next[id_rd_addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= '0;
            outstanding_q <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            fifo_cnt      <= 2'd0;
            wait_cnt      <= '0;
            hold_q        <= 1'b0;
        end else begin
            busy_q <= busy_next[31:1];
            case ({issue_long, retire})
                2'b10:   outstanding_q <= outstanding_q + 4'd1;
                2'b01:   outstanding_q <= outstanding_q - 4'd1;
                default: outstanding_q <= outstanding_q;
            endcase
            if (accept)
                wr_ptr <= ~wr_ptr;
            if (retire)
                rd_ptr <= ~rd_ptr;
            case ({accept, retire})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (!head_valid || retire)
                wait_cnt <= '0;
            else if (head_nz)
                wait_cnt <= wait_cnt + 1'b1;
            hold_q <= hold_next;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_addr[wr_ptr] <= lu_addr;
            fifo_data[wr_ptr] <= lu_data;
        end
    end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Randomized bench for rf_write_scheduler: a queue-based reference model predicts every
// cycle's outputs into a scoreboard; an independent monitor pops and compares.
module tb_rf_write_scheduler;

    localparam int MAXO = 4;
    localparam int SL   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_uses_rs1, id_uses_rs2, id_writes_rd, id_is_long;
    logic        id_stall;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        rf_regwrite;
    logic [4:0]  rf_writereg_addr;
    logic [31:0] rf_writedata;
    logic        pipe_hold;
    logic [31:0] busy_vec;
    logic [3:0]  outstanding;

    always #5 clk = ~clk;

    rf_write_scheduler #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rd_addr(id_rd_addr), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_writes_rd(id_writes_rd), .id_is_long(id_is_long), .id_stall(id_stall),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
        .rf_regwrite(rf_regwrite), .rf_writereg_addr(rf_writereg_addr),
        .rf_writedata(rf_writedata), .pipe_hold(pipe_hold), .busy_vec(busy_vec),
        .outstanding(outstanding)
    );

    typedef struct packed {
        logic        stall;
        logic        ready;
        logic        we;
        logic        hold;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] busy;
        logic [3:0]  outs;
    } exp_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    exp_t       exp_q[$];
    ent_t       m_fifo[$];
    logic [4:0] lu_pend[$];
    bit [31:0]  m_busy;
    int         m_outs;
    int         m_wait;
    bit         m_hold;
    int         n_vec  = 0;
    int         n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, expv);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("id_stall", 32'(id_stall), 32'(e.stall));
                check("lu_ready", 32'(lu_ready), 32'(e.ready));
                check("rf_regwrite", 32'(rf_regwrite), 32'(e.we));
                check("pipe_hold", 32'(pipe_hold), 32'(e.hold));
                check("busy_vec", busy_vec, e.busy);
                check("outstanding", 32'(outstanding), 32'(e.outs));
                if (e.we) begin
                    check("rf_writereg_addr", 32'(rf_writereg_addr), 32'(e.addr));
                    check("rf_writedata", rf_writedata, e.data);
                end
            end
        end
    end

    initial begin
        bit   id_keep, lu_held, wb_repeat, force_wb;
        bit   hv, written, retire, issue, accepted, new_hold;
        ent_t head;
        exp_t e;

        rst = 1'b1;
        id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; id_writes_rd = 0; id_is_long = 0;
        wb_we = 0; wb_addr = 0; wb_data = 0;
        lu_valid = 0; lu_addr = 0; lu_data = 0;
        m_busy = 0; m_outs = 0; m_wait = 0; m_hold = 0;
        id_keep = 0; lu_held = 0; wb_repeat = 0;
        repeat (2) @(posedge clk);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            #1;
            force_wb = ((cyc % 400) >= 300);
            rst = ($urandom_range(0, 199) == 0) || (cyc < 2);

            if (!id_keep) begin
                id_valid     = ($urandom_range(0, 3) != 0);
                id_rs1_addr  = 5'($urandom_range(0, 7));
                id_rs2_addr  = 5'($urandom_range(0, 7));
                id_rd_addr   = 5'($urandom_range(0, 7));
                id_uses_rs1  = 1'($urandom);
                id_uses_rs2  = 1'($urandom);
                id_writes_rd = ($urandom_range(0, 7) != 0);
                id_is_long   = ($urandom_range(0, 2) == 0);
            end
            if (!wb_repeat) begin
                wb_we   = force_wb ? 1'b1 : 1'($urandom);
                wb_addr = force_wb ? 5'($urandom_range(1, 15)) : 5'($urandom_range(0, 15));
                wb_data = $urandom;
            end
            if (!lu_held) begin
                if (lu_pend.size() != 0 && $urandom_range(0, 1) == 1) begin
                    lu_valid = 1'b1;
                    lu_addr  = lu_pend[0];
                    lu_data  = $urandom;
                end else begin
                    lu_valid = 1'b0;
                end
            end

            // Reference model: outputs for this cycle from the rules, then the edge update.
            hv   = (m_fifo.size() != 0);
            head = hv ? m_fifo[0] : '0;
            e.stall = id_valid && (rst
                      || (id_uses_rs1 && id_rs1_addr != 0 && m_busy[id_rs1_addr])
                      || (id_uses_rs2 && id_rs2_addr != 0 && m_busy[id_rs2_addr])
                      || (id_writes_rd && id_rd_addr != 0 && m_busy[id_rd_addr])
                      || (id_is_long && m_outs == MAXO)
                      || m_hold);
            e.ready = (m_fifo.size() < 2) && !rst;
            e.we = 1'b0; e.addr = '0; e.data = '0;
            written = 1'b0;
            if (!rst) begin
                if (m_hold && hv) begin
                    written = 1'b1;
                end else if (wb_we && wb_addr != 0 && !m_hold) begin
                    e.we = 1'b1; e.addr = wb_addr; e.data = wb_data;
                end else if (hv && head.addr != 0) begin
                    written = 1'b1;
                end
                if (written && head.addr != 0) begin
                    e.we = 1'b1; e.addr = head.addr; e.data = head.data;
                end
            end
            e.hold = m_hold;
            e.busy = m_busy;
            e.outs = 4'(m_outs);
            exp_q.push_back(e);

            if (rst) begin
                m_fifo.delete(); lu_pend.delete();
                m_busy = 0; m_outs = 0; m_wait = 0; m_hold = 0;
                id_keep = 0; lu_held = 0; wb_repeat = 0;
            end else begin
                retire   = hv && (head.addr == 0 || written);
                issue    = id_valid && !e.stall;
                accepted = lu_valid && e.ready;
                new_hold = hv && !retire && head.addr != 0 && m_wait == SL - 1;
                if (!hv || retire) m_wait = 0;
                else if (head.addr != 0) m_wait++;
                if (retire) begin
                    void'(m_fifo.pop_front());
                    if (head.addr != 0) m_busy[head.addr] = 1'b0;
                    m_outs--;
                end
                if (issue && id_is_long) begin
                    m_outs++;
                    if (id_writes_rd && id_rd_addr != 0) m_busy[id_rd_addr] = 1'b1;
                    lu_pend.push_back(id_writes_rd ? id_rd_addr : 5'd0);
                end
                if (accepted) begin
                    m_fifo.push_back({lu_addr, lu_data});
                    void'(lu_pend.pop_front());
                end
                lu_held   = lu_valid && !accepted;
                id_keep   = id_valid && e.stall;
                wb_repeat = m_hold && wb_we;
                m_hold    = new_hold;
            end
        end

        @(negedge clk);
        #3;
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
